// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store controller between the MEM stage and the unified memory data port.
// Accepts one request at a time, drives the memory's data-side signals and returns a
// registered response. Misaligned half/word accesses are either split into byte beats
// (LSU_MISALIGN_EN defined) or rejected with rsp_err (LSU_MISALIGN_EN undefined).
module lsu_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [2:0]        req_type,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_split,
    output logic              rsp_err,
    output logic              DMWr,
    output logic              DMRd,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_din,
    output logic [2:0]        DMType,
    input  logic [31:0]       dm_dout
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state_reg, state_next;
    logic              we_reg;
    logic [31:0]       wdata_reg;
    logic [2:0]        type_reg;
    logic              split_reg;
    logic              err_reg;
    logic [2:0]        nbytes_reg;
    logic [2:0]        cnt_reg;
    logic [31:0]       data_reg;
    logic [ADDR_W-1:0] dm_addr_reg;
    logic [31:0]       dm_din_reg;
    logic [2:0]        dm_type_reg;

    logic is_half, is_byte, is_word, misaligned, split_now, reject_now, last_beat;
    logic [1:0] cnt_inc;

    // Decode the incoming request: access size, misalignment and split/reject decision
    always_comb begin
        is_half    = (req_type == 3'b001) || (req_type == 3'b010);
        is_byte    = (req_type == 3'b011) || (req_type == 3'b100);
        is_word    = !is_half && !is_byte;
        misaligned = (is_half && req_addr[0]) || (is_word && (req_addr[1:0] != 2'b00));
`ifdef LSU_MISALIGN_EN
        split_now  = misaligned;
        reject_now = 1'b0;
`else
        split_now  = 1'b0;
        reject_now = misaligned;
`endif
        last_beat  = !split_reg || (cnt_reg == (nbytes_reg - 3'd1));
        cnt_inc    = cnt_reg[1:0] + 2'd1;
    end

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    // Next-state logic: rejected requests bypass ACCESS, split ones stay for nbytes beats
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (req_valid) state_next = reject_now ? RESP : ACCESS;
            ACCESS:  if (last_beat) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request latch, memory-side address/data/type registers and load data assembly
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            we_reg      <= 1'b0;
            wdata_reg   <= '0;
            type_reg    <= '0;
            split_reg   <= 1'b0;
            err_reg     <= 1'b0;
            nbytes_reg  <= '0;
            cnt_reg     <= '0;
            data_reg    <= '0;
            dm_addr_reg <= '0;
            dm_din_reg  <= '0;
            dm_type_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        we_reg     <= req_we;
                        wdata_reg  <= req_wdata;
                        type_reg   <= req_type;
                        split_reg  <= split_now;
                        err_reg    <= reject_now;
                        nbytes_reg <= is_word ? 3'd4 : 3'd2;
                        cnt_reg    <= '0;
                        data_reg   <= '0;
                        // A rejected request leaves the memory-side registers untouched
                        if (!reject_now) begin
                            dm_addr_reg <= req_addr;
                            if (split_now) begin
                                dm_type_reg <= req_we ? 3'b011 : 3'b100;
                                dm_din_reg  <= {24'b0, req_wdata[7:0]};
                            end else begin
                                dm_type_reg <= req_type;
                                dm_din_reg  <= req_wdata;
                            end
                        end
                    end
                end
                ACCESS: begin
                    if (split_reg) begin
                        if (!we_reg) data_reg[{cnt_reg[1:0], 3'b000} +: 8] <= dm_dout[7:0];
                        cnt_reg <= cnt_reg + 3'd1;
                        // Set up the next byte beat; address wraps modulo 2^ADDR_W
                        if (!last_beat) begin
                            dm_addr_reg <= dm_addr_reg + {{(ADDR_W-1){1'b0}}, 1'b1};
                            dm_din_reg  <= {24'b0, wdata_reg[{cnt_inc, 3'b000} +: 8]};
                        end
                    end else if (!we_reg) begin
                        data_reg <= dm_dout;
                    end
                end
                default: ;
            endcase
        end
    end

    // Response data: extend the captured/assembled bytes according to the access type
    always_comb begin
        rsp_rdata = '0;
        if (state_reg == RESP && !we_reg && !err_reg) begin
            case (type_reg)
                3'b001:  rsp_rdata = {{16{data_reg[15]}}, data_reg[15:0]};
                3'b010:  rsp_rdata = {16'b0, data_reg[15:0]};
                3'b011:  rsp_rdata = {{24{data_reg[7]}}, data_reg[7:0]};
                3'b100:  rsp_rdata = {24'b0, data_reg[7:0]};
                default: rsp_rdata = data_reg;
            endcase
        end
    end

    // Strobes derive from the state register so an async reset drops them at once
    assign req_ready = (state_reg == IDLE);
    assign rsp_valid = (state_reg == RESP);
    assign rsp_split = (state_reg == RESP) && split_reg;
    assign rsp_err   = (state_reg == RESP) && err_reg;
    assign DMWr      = (state_reg == ACCESS) && we_reg;
    assign DMRd      = (state_reg == ACCESS) && !we_reg;
    assign dm_addr   = dm_addr_reg;
    assign dm_din    = dm_din_reg;
    assign DMType    = dm_type_reg;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Testbench for lsu_ctrl: byte-addressed memory model, scoreboard of expected responses,
// directed load/store sequence. Misaligned-split cases are built when LSU_MISALIGN_EN is set.
module tb_lsu_ctrl;

    logic        clk;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_type;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_split;
    logic        rsp_err;
    logic        DMWr;
    logic        DMRd;
    logic [31:0] dm_addr;
    logic [31:0] dm_din;
    logic [2:0]  DMType;
    logic [31:0] dm_dout;

    lsu_ctrl #(.ADDR_W(32)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_type(req_type),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_split(rsp_split), .rsp_err(rsp_err),
        .DMWr(DMWr), .DMRd(DMRd), .dm_addr(dm_addr), .dm_din(dm_din), .DMType(DMType),
        .dm_dout(dm_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: 4 KiB, address bits [11:0], little-endian, combinational read
    logic [7:0]  mem [0:4095];
    logic [11:0] a0, a1, a2, a3;
    logic [7:0]  b0, b1, b2, b3;
    assign a0 = dm_addr[11:0];
    assign a1 = a0 + 12'd1;
    assign a2 = a0 + 12'd2;
    assign a3 = a0 + 12'd3;

    always_comb begin
        b0 = mem[a0];
        b1 = mem[a1];
        b2 = mem[a2];
        b3 = mem[a3];
        dm_dout = 32'h0;
        if (DMRd) begin
            case (DMType)
                3'b001:  dm_dout = {{16{b1[7]}}, b1, b0};
                3'b010:  dm_dout = {16'h0, b1, b0};
                3'b011:  dm_dout = {{24{b0[7]}}, b0};
                3'b100:  dm_dout = {24'h0, b0};
                default: dm_dout = {b3, b2, b1, b0};
            endcase
        end
    end

    always @(posedge clk) begin
        if (rstn && DMWr) begin
            case (DMType)
                3'b001, 3'b010: begin
                    mem[a0] <= dm_din[7:0];
                    mem[a1] <= dm_din[15:8];
                end
                3'b011, 3'b100: mem[a0] <= dm_din[7:0];
                default: begin
                    mem[a0] <= dm_din[7:0];
                    mem[a1] <= dm_din[15:8];
                    mem[a2] <= dm_din[23:16];
                    mem[a3] <= dm_din[31:24];
                end
            endcase
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic        split;
        logic        err;
        int          lat;
        int          wr;
        int          rd;
    } exp_t;

    exp_t sb[$];

    int errors = 0;
    int checks = 0;
    logic [31:0] first_addr, first_din;
    logic [2:0]  first_type;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One request through the handshake; expectation is queued at drive time and
    // compared when rsp_valid appears (bounded wait)
    task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [2:0] typ,
                       input logic [31:0] e_rdata, input logic e_split, input logic e_err,
                       input int e_lat, input int e_wr, input int e_rd);
        exp_t e, g;
        int lat, wr, rd;
        bit seen;
        e.rdata = e_rdata; e.split = e_split; e.err = e_err;
        e.lat = e_lat; e.wr = e_wr; e.rd = e_rd;
        @(negedge clk);
        chk({tag, ".ready"}, {31'b0, req_ready}, 32'd1);
        sb.push_back(e);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_type = typ;
        @(posedge clk);
        lat = 0; wr = 0; rd = 0; seen = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if ((DMWr || DMRd) && wr == 0 && rd == 0) begin
                first_addr = dm_addr; first_din = dm_din; first_type = DMType;
            end
            if (DMWr) wr++;
            if (DMRd) rd++;
            if (rsp_valid) begin
                lat = i;
                seen = 1'b1;
                break;
            end
        end
        g = sb.pop_front();
        chk({tag, ".seen"}, {31'b0, seen}, 32'd1);
        if (seen) begin
            chk({tag, ".rdata"}, rsp_rdata, g.rdata);
            chk({tag, ".split"}, {31'b0, rsp_split}, {31'b0, g.split});
            chk({tag, ".err"}, {31'b0, rsp_err}, {31'b0, g.err});
            chk({tag, ".lat"}, lat, g.lat);
            chk({tag, ".wr"}, wr, g.wr);
            chk({tag, ".rd"}, rd, g.rd);
        end
        $display("txn %s we=%0b addr=%h type=%0d rdata=%h split=%0b err=%0b lat=%0d",
                 tag, we, addr, typ, rsp_rdata, rsp_split, rsp_err, lat);
    endtask

    // Accept a request, let nbeats ACCESS beats elapse, then pulse reset in the next beat
    task automatic reset_mid(input string tag, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [2:0] typ,
                             input int nbeats, input logic [31:0] e_addr);
        int hits;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_type = typ;
        @(posedge clk);
        for (int i = 0; i <= nbeats; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
        chk({tag, ".en_before"}, {30'b0, DMWr, DMRd}, we ? 32'd2 : 32'd1);
        chk({tag, ".addr_before"}, dm_addr, e_addr);
        #2 rstn = 1'b0;
        #1;
        chk({tag, ".en_after"}, {30'b0, DMWr, DMRd}, 32'd0);
        chk({tag, ".vld_after"}, {31'b0, rsp_valid}, 32'd0);
        chk({tag, ".addr_after"}, dm_addr, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        hits = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid) hits++;
        end
        chk({tag, ".no_rsp"}, hits, 32'd0);
        chk({tag, ".ready"}, {31'b0, req_ready}, 32'd1);
        $display("reset %s addr=%h done", tag, addr);
    endtask

    initial begin
        rstn = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_addr = '0; req_wdata = '0; req_type = '0;
        #12;
        chk("rst.ready", {31'b0, req_ready}, 32'd1);
        chk("rst.flags", {26'b0, rsp_valid, rsp_split, rsp_err, DMWr, DMRd, 1'b0}, 32'd0);
        chk("rst.rdata", rsp_rdata, 32'd0);
        chk("rst.addr", dm_addr, 32'd0);
        chk("rst.din", dm_din, 32'd0);
        chk("rst.type", {29'b0, DMType}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Aligned word store/load
        txn("sw100", 1'b1, 32'h100, 32'hDEADBEEF, 3'b000, 32'h0, 1'b0, 1'b0, 2, 1, 0);
        chk("sw100.beat_addr", first_addr, 32'h100);
        chk("sw100.beat_type", {29'b0, first_type}, 32'd0);
        chk("sw100.beat_din", first_din, 32'hDEADBEEF);
        txn("lw100", 1'b0, 32'h100, 32'h0, 3'b000, 32'hDEADBEEF, 1'b0, 1'b0, 2, 0, 1);

        // Signed/unsigned halves and bytes
        txn("sw200", 1'b1, 32'h200, 32'h80017FFF, 3'b000, 32'h0, 1'b0, 1'b0, 2, 1, 0);
        txn("lh202", 1'b0, 32'h202, 32'h0, 3'b001, 32'hFFFF8001, 1'b0, 1'b0, 2, 0, 1);
        txn("lhu202", 1'b0, 32'h202, 32'h0, 3'b010, 32'h00008001, 1'b0, 1'b0, 2, 0, 1);
        txn("lh200", 1'b0, 32'h200, 32'h0, 3'b001, 32'h00007FFF, 1'b0, 1'b0, 2, 0, 1);
        txn("lb203", 1'b0, 32'h203, 32'h0, 3'b011, 32'hFFFFFF80, 1'b0, 1'b0, 2, 0, 1);
        txn("lbu203", 1'b0, 32'h203, 32'h0, 3'b100, 32'h00000080, 1'b0, 1'b0, 2, 0, 1);
        txn("lb200", 1'b0, 32'h200, 32'h0, 3'b011, 32'hFFFFFFFF, 1'b0, 1'b0, 2, 0, 1);

        // Narrow stores merge into the word; type 101 reads as a word
        txn("sb101", 1'b1, 32'h101, 32'h123456A5, 3'b011, 32'h0, 1'b0, 1'b0, 2, 1, 0);
        chk("sb101.beat_type", {29'b0, first_type}, 32'd3);
        chk("sb101.beat_addr", first_addr, 32'h101);
        txn("sh102", 1'b1, 32'h102, 32'h0000CAFE, 3'b001, 32'h0, 1'b0, 1'b0, 2, 1, 0);
        txn("lw100b", 1'b0, 32'h100, 32'h0, 3'b000, 32'hCAFEA5EF, 1'b0, 1'b0, 2, 0, 1);
        txn("l101t", 1'b0, 32'h100, 32'h0, 3'b101, 32'hCAFEA5EF, 1'b0, 1'b0, 2, 0, 1);

`ifdef LSU_MISALIGN_EN
        // Misaligned word split into four byte beats
        txn("sw301", 1'b1, 32'h301, 32'h11223344, 3'b000, 32'h0, 1'b1, 1'b0, 5, 4, 0);
        chk("sw301.beat_type", {29'b0, first_type}, 32'd3);
        chk("sw301.beat_din", first_din, 32'h44);
        chk("mem301", {24'b0, mem[12'h301]}, 32'h44);
        chk("mem302", {24'b0, mem[12'h302]}, 32'h33);
        chk("mem303", {24'b0, mem[12'h303]}, 32'h22);
        chk("mem304", {24'b0, mem[12'h304]}, 32'h11);
        txn("lw301", 1'b0, 32'h301, 32'h0, 3'b000, 32'h11223344, 1'b1, 1'b0, 5, 0, 4);

        // Misaligned halves, including address wrap
        txn("sb403", 1'b1, 32'h403, 32'h80, 3'b011, 32'h0, 1'b0, 1'b0, 2, 1, 0);
        txn("sb404", 1'b1, 32'h404, 32'h12, 3'b011, 32'h0, 1'b0, 1'b0, 2, 1, 0);
        txn("lh403", 1'b0, 32'h403, 32'h0, 3'b001, 32'h00001280, 1'b1, 1'b0, 3, 0, 2);
        txn("sh403", 1'b1, 32'h403, 32'hFFFE, 3'b001, 32'h0, 1'b1, 1'b0, 3, 2, 0);
        txn("lh403b", 1'b0, 32'h403, 32'h0, 3'b001, 32'hFFFFFFFE, 1'b1, 1'b0, 3, 0, 2);
        txn("lhu403", 1'b0, 32'h403, 32'h0, 3'b010, 32'h0000FFFE, 1'b1, 1'b0, 3, 0, 2);
        txn("sbfff", 1'b1, 32'hFFFFFFFF, 32'h5A, 3'b011, 32'h0, 1'b0, 1'b0, 2, 1, 0);
        txn("sb000", 1'b1, 32'h0, 32'h6B, 3'b011, 32'h0, 1'b0, 1'b0, 2, 1, 0);
        txn("lhufff", 1'b0, 32'hFFFFFFFF, 32'h0, 3'b010, 32'h00006B5A, 1'b1, 1'b0, 3, 0, 2);

        // Reset during beat 2 of a split store: earlier bytes stay written
        txn("sw500", 1'b1, 32'h500, 32'h0, 3'b000, 32'h0, 1'b0, 1'b0, 2, 1, 0);
        txn("sw504", 1'b1, 32'h504, 32'h0, 3'b000, 32'h0, 1'b0, 1'b0, 2, 1, 0);
        reset_mid("sw501", 1'b1, 32'h501, 32'hAABBCCDD, 3'b000, 2, 32'h503);
        chk("mem501", {24'b0, mem[12'h501]}, 32'hDD);
        chk("mem502", {24'b0, mem[12'h502]}, 32'hCC);
        chk("mem503", {24'b0, mem[12'h503]}, 32'h00);
`else
        // Misaligned requests are rejected without touching memory
        txn("lw102", 1'b0, 32'h102, 32'h0, 3'b000, 32'h0, 1'b0, 1'b1, 1, 0, 0);
        txn("sw101", 1'b1, 32'h101, 32'h11223344, 3'b000, 32'h0, 1'b0, 1'b1, 1, 0, 0);
        txn("lh201", 1'b0, 32'h201, 32'h0, 3'b001, 32'h0, 1'b0, 1'b1, 1, 0, 0);
        txn("lhu203", 1'b0, 32'h203, 32'h0, 3'b010, 32'h0, 1'b0, 1'b1, 1, 0, 0);
        txn("l102t6", 1'b0, 32'h102, 32'h0, 3'b110, 32'h0, 1'b0, 1'b1, 1, 0, 0);
        txn("lw100c", 1'b0, 32'h100, 32'h0, 3'b000, 32'hCAFEA5EF, 1'b0, 1'b0, 2, 0, 1);
        chk("lw100c.beat_addr", first_addr, 32'h100);

        // Reset during an aligned load access
        reset_mid("lw100r", 1'b0, 32'h100, 32'h0, 3'b000, 0, 32'h100);
`endif
        txn("lw100d", 1'b0, 32'h100, 32'h0, 3'b000, 32'hCAFEA5EF, 1'b0, 1'b0, 2, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store controller between the MEM pipeline stage and the data port of the unified memory. It accepts one load or store request at a time over a valid/ready handshake and drives the memory's data-side signals (DMWr, DMRd, dm_addr, dm_din, DMType). It reads dm_dout combinationally and returns a registered response. Misaligned halfword and word accesses are split into sequential byte accesses, assembled little-endian, then sign- or zero-extended.

## Interface
- ADDR_W, 32, request/memory address width
- clk  in  1  clock; all state on rising edge
- rstn  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept (high only in IDLE)
- req_we  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, little-endian bytes
- req_type  in  3  000 word, 001 half, 010 half unsigned, 011 byte, 100 byte unsigned; 101–111 treated as word
- rsp_valid  out  1  one-cycle completion pulse (loads and stores)
- rsp_rdata  out  32  extended load data; 0 for stores
- rsp_split  out  1  with rsp_valid: access was split into byte accesses
- rsp_err  out  1  with rsp_valid: misaligned request rejected (only without macro)
- DMWr  out  1  memory write enable
- DMRd  out  1  memory read enable
- dm_addr  out  ADDR_W  memory byte address
- dm_din  out  32  memory write data
- DMType  out  3  memory access type, same encoding as req_type
- dm_dout  in  32  memory read data, combinational from dm_addr/DMType/DMRd

## Operation
- States are IDLE, ACCESS and RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch we/addr/wdata/type.
  - Compute misaligned: half/hu with addr[0]=1, or word with addr[1:0]≠0. Byte accesses are never misaligned.
  - Set nbytes = 2 (half) or 4 (word) for split accesses, 1 beat otherwise.
  - Clear the byte counter cnt and the assembly register, then go to ACCESS.
- ACCESS, aligned:
  - One beat: dm_addr=addr, DMType=type, DMRd=!we, DMWr=we, dm_din=wdata.
  - Loads capture dm_dout as the final data.
  - Go to RESP.
- ACCESS, split:
  - Beat k (0..nbytes−1): dm_addr=addr+k (modulo 2^ADDR_W), DMType=100 for loads and 011 for stores, dm_din={24'b0, wdata[8k+7:8k]}.
  - Loads store dm_dout[7:0] into assembly byte k.
  - cnt increments each beat; after beat nbytes−1, go to RESP.
- RESP:
  - rsp_valid=1.
  - rsp_rdata: assembled/captured data extended per type (001 sign from bit 15, 010 zero, word unchanged); 0 for stores.
  - rsp_split reflects the split decision.
  - Next state IDLE.
- DMRd/DMWr are 0 outside ACCESS. dm_addr/dm_din/DMType hold their last values.
- A split store is not atomic. Bytes written before an abort remain in memory.

## Timing
- Reset (async, immediate): state IDLE. req_ready=1; rsp_valid, rsp_rdata, rsp_split, rsp_err, DMWr, DMRd, dm_addr, dm_din, DMType all 0.
- Aligned latency: request accepted at edge N, memory access during cycle N+1, rsp_valid during cycle N+2. Next accept at edge N+3.
- Split latency: nbytes access cycles, then RESP. A misaligned word gives rsp_valid 5 cycles after acceptance.
- The memory write commits on the rising edge that ends each ACCESS beat.
- Load data is sampled at the end of each ACCESS beat (combinational read).
- req_valid while req_ready=0 is ignored. The requester holds it until accepted.
- Reset mid-ACCESS: DMWr/DMRd drop asynchronously and no rsp_valid is produced.
- Address wrap: addr 0xFFFF_FFFF + 1 wraps to 0x0000_0000.

## Configuration
- LSU_MISALIGN_EN defined: misaligned requests are split as above and rsp_err is always 0.
- LSU_MISALIGN_EN undefined:
  - A misaligned request skips ACCESS and makes no memory access; IDLE goes directly to RESP.
  - In RESP: rsp_err=1, rsp_rdata=0, rsp_split=0.
  - Aligned behaviour is unchanged.

## Test plan
- Aligned word: store 0xDEADBEEF at 0x100, then load word at 0x100. Expect one DMWr beat with DMType=000, then rsp_rdata=0xDEADBEEF, rsp_split=0, rsp_valid 2 cycles after accept.
- Signed/unsigned half: memory word 0x8001_7FFF at 0x200. lh at 0x202 → 0xFFFF8001; lhu at 0x202 → 0x00008001; lh at 0x200 → 0x00007FFF.
- Misaligned word store/load (macro on): sw 0x11223344 at 0x301 produces 4 byte writes 0x301..0x304 (0x44, 0x33, 0x22, 0x11). lw at 0x301 then returns 0x11223344 with rsp_split=1, 5 cycles after accept.
- Misaligned half load (macro on): bytes 0x80 at 0x403 and 0x12 at 0x404. lh at 0x403 → 0x00001280; bytes 0xFE at 0x403 and 0xFF at 0x404 → 0xFFFFFFFE.
- Macro off: lw at 0x102 gives rsp_err=1, rsp_rdata=0, and no DMRd/DMWr for the whole transaction.
- Reset mid-split: assert rstn=0 during beat 2 of a misaligned sw. DMWr drops immediately, no rsp_valid, req_ready=1 after release, bytes from beats 0–1 remain in memory.
